fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares the single write port of `sync_fifo` among NUM_REQ producers.
- Each producer presents data with a valid/ready handshake.
- The arbiter grants one producer at a time for a bounded burst and drives the FIFO's `wr_en`/`data_in`.
- It stalls on `full` without dropping data.
- Sits directly in front of `sync_fifo`; the FIFO read side is untouched.

Parameters:
- NUM_REQ, 4, number of producers (2..8).
- DATA_WIDTH, 8, word width; must match the FIFO data width.
- BURST_MAX, 4, maximum transfers per grant before forced rotation (1..255).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- req_valid  in  NUM_REQ  per-producer valid.
- req_data  in  NUM_REQ*DATA_WIDTH  flat data; producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-producer ready; at most one bit high.
- fifo_full  in  1  `full` from `sync_fifo`.
- fifo_wr_en  out  1  to FIFO `wr_en`.
- fifo_data_in  out  DATA_WIDTH  to FIFO `data_in`.
- grant_id  out  max(1,$clog2(NUM_REQ))  index of the current grantee; valid when busy=1.
- busy  out  1  high while in GRANT state.

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE, rr_ptr=0, grant_id=0, burst_cnt=0, busy=0.
  - Combinationally req_ready=0, fifo_wr_en=0, fifo_data_in=0.
  - Reset mid-burst abandons the grant; no partial state is kept.
- State register holds IDLE or GRANT. Registered: rr_ptr, grant_id, burst_cnt (8 bit).
- IDLE:
  - If any req_valid, select the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Register grant_id=selected, burst_cnt=0, and enter GRANT next cycle.
  - No transfer occurs in IDLE, giving 1 cycle arbitration latency.
- GRANT, with g=grant_id:
  - req_ready[g] = ~fifo_full, combinational; all other ready bits are 0.
  - Transfer happens when req_valid[g] & req_ready[g]. Then fifo_wr_en=1 and fifo_data_in=req_data[g] in the same cycle (zero-latency passthrough).
  - With no transfer: fifo_wr_en=0 and fifo_data_in=0.
  - Each transfer increments burst_cnt.
- Leave GRANT to IDLE, setting rr_ptr=(g+1) mod NUM_REQ, when either:
  - (a) a transfer occurs with burst_cnt==BURST_MAX-1, or
  - (b) req_valid[g]=0 in a cycle.
  - One idle bubble between grants is required and intended.
- fifo_full=1 while in GRANT: hold the grant, keep burst_cnt unchanged, no timeout. fifo_wr_en is never asserted while fifo_full=1.
- A non-granted producer with valid high simply waits. Producers must hold req_data stable while valid & ~ready. Dropping valid before ready is permitted; that producer forfeits its grant.
- Fairness: with all producers continuously valid, grants rotate 0,1,2,3,0… and each grant carries exactly BURST_MAX words.

Optional Feature:
Macro `FIFO_ARB_STATS_EN`.
- Defined:
  - Adds input `stat_clr` (1) and output `stat_count` (NUM_REQ*16), with producer i at [i*16 +: 16].
  - Each counter increments on every transfer by producer i and saturates at 16'hFFFF.
  - Counters clear on reset or when stat_clr=1; clear wins over a same-cycle increment.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with all req_valid=1 -> req_ready=0, fifo_wr_en=0, busy=0. After release, first grant_id=0 one cycle later.
2. Single producer: req_valid=4'b0100 with data 8'hA1,8'hB2,8'hC3, then valid drops -> grant_id=2; FIFO receives A1,B2,C3 on 3 consecutive cycles; then IDLE and rr_ptr=3.
3. Round-robin and burst: all 4 valid continuously, BURST_MAX=4, producer i sends 8'hi0..8'hi3 -> FIFO order 00..03,10..13,20..23,30..33,00..; one bubble between bursts.
4. Full stall: fifo_full=1 after 2 words of a burst from producer 1, held 5 cycles -> fifo_wr_en=0 and req_ready=0 for 5 cycles; grant_id stays 1; the remaining 2 words follow with no loss or duplication.
5. Early deassert: producer 3 drops valid after 1 word while producer 0 is valid -> next grant goes to 0 after 1 bubble; producer 3 wrote exactly 1 word.
6. Stats (FIFO_ARB_STATS_EN): run scenario 3 for 32 transfers -> stat_count of each producer = 8. Pulse stat_clr -> all counters 0 the next cycle.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one sync_fifo write port among NUM_REQ valid/ready producers.
// Optional per-producer transfer counters are enabled with `define FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 4,
  localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [GW-1:0]                 grant_id,
  output logic                          busy
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic                          stat_clr,
  output logic [NUM_REQ*16-1:0]         stat_count
`endif
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_next;
  logic [GW-1:0]   rr_ptr, rr_next;
  logic [GW-1:0]   grant_next;
  logic [7:0]      burst_cnt, burst_next;
  logic [GW-1:0]   cand;
  logic [GW-1:0]   sel_id;
  logic            sel_found;
  logic            xfer;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // First valid requester at or above rr_ptr, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = GW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_next;
      rr_ptr    <= rr_next;
      grant_id  <= grant_next;
      burst_cnt <= burst_next;
    end
  end

  always_comb begin
    state_next   = state;
    rr_next      = rr_ptr;
    grant_next   = grant_id;
    burst_next   = burst_cnt;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_data_in = '0;
    xfer         = 1'b0;
    case (state)
      IDLE: begin
        if (sel_found) begin
          grant_next = sel_id;
          burst_next = '0;
          state_next = GRANT;
        end
      end
      GRANT: begin
        req_ready[grant_id] = ~fifo_full;
        xfer = req_valid[grant_id] & ~fifo_full;
        if (xfer) begin
          fifo_wr_en   = 1'b1;
          fifo_data_in = data_arr[grant_id];
          burst_next   = burst_cnt + 8'd1;
        end
        // A stalled grant (full, still valid) is held indefinitely.
        if ((xfer && burst_cnt == 8'(BURST_MAX - 1)) || !req_valid[grant_id]) begin
          state_next = IDLE;
          rr_next    = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == GRANT);

`ifdef FIFO_ARB_STATS_EN
  logic [NUM_REQ-1:0] xfer_vec;
  logic [15:0]        stat_reg [NUM_REQ];

  assign xfer_vec = req_valid & req_ready;

  // Clear has priority over a same-cycle increment; counters saturate.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!rst || stat_clr)
        stat_reg[i] <= '0;
      else if (xfer_vec[i] && stat_reg[i] != 16'hFFFF)
        stat_reg[i] <= stat_reg[i] + 16'd1;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    assign stat_count[i*16 +: 16] = stat_reg[i];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: per-cycle vector table plus scoreboarded burst sequences.
// Stats checks are compiled in when FIFO_ARB_STATS_EN is defined.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_data_in;
  logic [1:0]  grant_id;
  logic        busy;
`ifdef FIFO_ARB_STATS_EN
  logic        stat_clr;
  logic [63:0] stat_count;
`endif

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_MAX(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .grant_id     (grant_id),
    .busy         (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_clr     (stat_clr),
    .stat_count   (stat_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        full;
    logic        chk;
    logic [3:0]  ready;
    logic        wr;
    logic [7:0]  dout;
    logic        busy;
    logic [1:0]  gid;
  } vec_t;

  vec_t        vecs[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cnt[4];
  logic        exp_wr_q[$];
  logic [7:0]  exp_data_q[$];
  logic [1:0]  last_gid;

  localparam logic [31:0] D0 = 32'h3322_1100;

  function automatic vec_t mv(logic r, logic [3:0] v, logic [31:0] d, logic f, logic c,
                              logic [3:0] rdy, logic w, logic [7:0] o, logic b, logic [1:0] g);
    vec_t x;
    x.rst = r; x.valid = v; x.data = d; x.full = f; x.chk = c;
    x.ready = rdy; x.wr = w; x.dout = o; x.busy = b; x.gid = g;
    return x;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic apply_stimulus(input int idx, input vec_t v);
    rst       = v.rst;
    req_valid = v.valid;
    req_data  = v.data;
    fifo_full = v.full;
    @(negedge clk);
    if (v.chk) begin
      check_output($sformatf("v%0d_ready", idx), 32'(req_ready), 32'(v.ready));
      check_output($sformatf("v%0d_wr_en", idx), 32'(fifo_wr_en), 32'(v.wr));
      check_output($sformatf("v%0d_data", idx), 32'(fifo_data_in), 32'(v.dout));
      check_output($sformatf("v%0d_busy", idx), 32'(busy), 32'(v.busy));
      check_output($sformatf("v%0d_gid", idx), 32'(grant_id), 32'(v.gid));
    end
    @(posedge clk); #1;
  endtask

  // One cycle of free-running producers: producer i offers {i, word index mod 4}.
  task automatic run_cycle(input logic [3:0] valid, input logic full);
    req_valid = valid;
    fifo_full = full;
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = {4'(i), 4'(cnt[i] % 4)};
    @(negedge clk);
    if (exp_wr_q.size() == 0) begin
      n_checks++;
      $display("[TB] FAIL sb_cycle: got an unplanned cycle, expected none");
    end else begin
      check_output("sb_wr_en", 32'(fifo_wr_en), 32'(exp_wr_q.pop_front()));
    end
    if (fifo_wr_en) begin
      if (exp_data_q.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL sb_extra: got write 0x%0h, expected no write", fifo_data_in);
      end else begin
        check_output("sb_data", 32'(fifo_data_in), 32'(exp_data_q.pop_front()));
      end
    end
    if (full) check_output("stall_ready", 32'(req_ready), 32'd0);
    last_gid = grant_id;
    for (int i = 0; i < 4; i++) if (req_valid[i] && req_ready[i]) cnt[i]++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_valid = '0;
    fifo_full = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic full_pat [11];
    logic wr_pat   [11];
    rst = 1'b0; req_valid = '0; req_data = '0; fifo_full = 1'b0;
`ifdef FIFO_ARB_STATS_EN
    stat_clr = 1'b0;
`endif

    // rst v data full chk ready wr dout busy gid
    vecs.push_back(mv(0, 4'b1111, D0,            0, 1, 4'b0000, 0, 8'h00, 0, 0));
    vecs.push_back(mv(0, 4'b1111, D0,            0, 1, 4'b0000, 0, 8'h00, 0, 0));
    vecs.push_back(mv(1, 4'b1111, 32'h3322115A,  0, 1, 4'b0000, 0, 8'h00, 0, 0));
    vecs.push_back(mv(1, 4'b1111, 32'h3322115A,  0, 1, 4'b0001, 1, 8'h5A, 1, 0));
    vecs.push_back(mv(0, 4'b1111, D0,            0, 0, 4'b0000, 0, 8'h00, 0, 0));
    vecs.push_back(mv(0, 4'b1111, D0,            0, 1, 4'b0000, 0, 8'h00, 0, 0));
    vecs.push_back(mv(1, 4'b0000, D0,            0, 1, 4'b0000, 0, 8'h00, 0, 0));
    vecs.push_back(mv(1, 4'b0100, 32'h00A10000,  0, 1, 4'b0000, 0, 8'h00, 0, 0));
    vecs.push_back(mv(1, 4'b0100, 32'h00A10000,  0, 1, 4'b0100, 1, 8'hA1, 1, 2));
    vecs.push_back(mv(1, 4'b0100, 32'h00B20000,  0, 1, 4'b0100, 1, 8'hB2, 1, 2));
    vecs.push_back(mv(1, 4'b0100, 32'h00C30000,  0, 1, 4'b0100, 1, 8'hC3, 1, 2));
    vecs.push_back(mv(1, 4'b0000, 32'h00C30000,  0, 1, 4'b0100, 0, 8'h00, 1, 2));
    vecs.push_back(mv(1, 4'b0000, D0,            0, 1, 4'b0000, 0, 8'h00, 0, 2));
    vecs.push_back(mv(1, 4'b1111, D0,            0, 1, 4'b0000, 0, 8'h00, 0, 2));
    vecs.push_back(mv(1, 4'b1111, D0,            0, 1, 4'b1000, 1, 8'h33, 1, 3));
    vecs.push_back(mv(1, 4'b0000, D0,            0, 1, 4'b1000, 0, 8'h00, 1, 3));
    vecs.push_back(mv(1, 4'b0000, D0,            0, 1, 4'b0000, 0, 8'h00, 0, 3));
    vecs.push_back(mv(1, 4'b1000, 32'hD70000E0,  0, 1, 4'b0000, 0, 8'h00, 0, 3));
    vecs.push_back(mv(1, 4'b1001, 32'hD70000E0,  0, 1, 4'b1000, 1, 8'hD7, 1, 3));
    vecs.push_back(mv(1, 4'b0001, 32'hD70000E0,  0, 1, 4'b1000, 0, 8'h00, 1, 3));
    vecs.push_back(mv(1, 4'b0001, 32'hD70000E0,  0, 1, 4'b0000, 0, 8'h00, 0, 3));
    vecs.push_back(mv(1, 4'b0001, 32'hD70000E0,  1, 1, 4'b0000, 0, 8'h00, 1, 0));
    vecs.push_back(mv(1, 4'b0001, 32'hD70000E0,  0, 1, 4'b0001, 1, 8'hE0, 1, 0));
    vecs.push_back(mv(1, 4'b0000, D0,            0, 1, 4'b0001, 0, 8'h00, 1, 0));
    vecs.push_back(mv(1, 4'b0000, D0,            0, 1, 4'b0000, 0, 8'h00, 0, 0));

    $display("[TB] vector table: %0d entries", vecs.size());
    foreach (vecs[i]) apply_stimulus(i, vecs[i]);

    // All producers valid: 8 full bursts in strict rotation with one bubble each.
    $display("[TB] round-robin burst sequence");
    do_reset();
    exp_wr_q.push_back(1'b0);
    for (int b = 0; b < 8; b++) begin
      for (int w = 0; w < 4; w++) begin
        exp_wr_q.push_back(1'b1);
        exp_data_q.push_back({4'(b % 4), 4'(w)});
      end
      exp_wr_q.push_back(1'b0);
    end
    for (int c = 0; c < 41; c++) run_cycle(4'b1111, 1'b0);
    check_output("rr_drain", 32'(exp_data_q.size()), 32'd0);
`ifdef FIFO_ARB_STATS_EN
    for (int p = 0; p < 4; p++)
      check_output($sformatf("stat_%0d", p), 32'(stat_count[p*16 +: 16]), 32'd8);
    req_valid = '0;
    stat_clr  = 1'b1;
    @(posedge clk); #1;
    stat_clr  = 1'b0;
    for (int p = 0; p < 4; p++)
      check_output($sformatf("stat_clr_%0d", p), 32'(stat_count[p*16 +: 16]), 32'd0);
`endif

    // Producer 1 stalled by full for 5 cycles after two words.
    $display("[TB] full stall sequence");
    do_reset();
    full_pat = '{0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0};
    wr_pat   = '{0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0};
    for (int c = 0; c < 11; c++) exp_wr_q.push_back(wr_pat[c]);
    for (int w = 0; w < 4; w++) exp_data_q.push_back({4'd1, 4'(w)});
    for (int c = 0; c < 11; c++) begin
      run_cycle((c < 10) ? 4'b0010 : 4'b0000, full_pat[c]);
      if (full_pat[c]) check_output("stall_gid", 32'(last_gid), 32'd1);
    end
    check_output("stall_drain", 32'(exp_data_q.size() + exp_wr_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
